// File: rtl/cayde_multicycle_ctrl_if.sv
// cayde_multicycle_ctrl_if: instruction/data memory handshake bundle for the multicycle sequencer
//   master (sequencer): imem_req, imem_addr, dmem_req, dmem_we out; imem_rdata, imem_valid, dmem_ready in
//   slave  (memories) : the same signals in the opposite direction
interface cayde_multicycle_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    modport master (output imem_req, imem_addr, dmem_req, dmem_we, input imem_rdata, imem_valid, dmem_ready);
    modport slave (input imem_req, imem_addr, dmem_req, dmem_we, output imem_rdata, imem_valid, dmem_ready);
endinterface

// File: rtl/cayde_multicycle_ctrl.sv
// cayde_multicycle_ctrl: multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer owning PC, IR and retire count
//   clk, rst_n          clock, asynchronous active-low reset
//   mem                 imem/dmem request handshakes (master side)
//   pc_o, ir_o          current PC and latched instruction
//   pc_target_i         branch/JAL target, branch_taken_i sampled in EXECUTE
//   alu_op_o, funct3_o, funct7_o, alu_src_imm_o, wb_sel_o   datapath controls
//   rf_we_o, trap_o, retired_o                               write strobe, sticky illegal flag, retire count
module cayde_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cayde_multicycle_ctrl_if.master mem,
    output logic [31:0]          pc_o,
    input  logic [31:0]          pc_target_i,
    input  logic                 branch_taken_i,
    output logic [31:0]          ir_o,
    output logic [1:0]           alu_op_o,
    output logic [2:0]           funct3_o,
    output logic [6:0]           funct7_o,
    output logic                 alu_src_imm_o,
    output logic                 rf_we_o,
    output logic [1:0]           wb_sel_o,
    output logic                 trap_o,
    output logic [CNT_W-1:0]     retired_o
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd7
    } state_e;
    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d, ir_q, ir_d, pc_plus4;
    logic [CNT_W-1:0]   retired_q, retired_d, retired_inc;
    logic               is_r, is_i, is_ld, is_st, is_br, is_jal, dec_en;
    logic               imem_req_c, dmem_req_c, dmem_we_c, rf_we_c;
    assign is_r   = ir_q[6:0] == 7'b0110011;
    assign is_i   = ir_q[6:0] == 7'b0010011;
    assign is_ld  = ir_q[6:0] == 7'b0000011;
    assign is_st  = ir_q[6:0] == 7'b0100011;
    assign is_br  = ir_q[6:0] == 7'b1100011;
    assign is_jal = ir_q[6:0] == 7'b1101111;
    assign pc_plus4    = pc_q + 32'd4;
    assign retired_inc = retired_q + CNT_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_valid) begin
                    ir_d    = mem.imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = (is_r || is_i || is_ld || is_st || is_br || is_jal) ? EXECUTE : TRAP;
            EXECUTE: begin
                if (is_br) begin
                    pc_d      = branch_taken_i ? pc_target_i : pc_plus4;
                    retired_d = retired_inc;
                    state_d   = FETCH;
                end else begin
                    state_d = (is_ld || is_st) ? MEMORY : WRITEBACK;
                end
            end
            MEMORY: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_st;
                if (mem.dmem_ready) begin
                    pc_d      = is_st ? pc_plus4 : pc_q;
                    retired_d = is_st ? retired_inc : retired_q;
                    state_d   = is_st ? FETCH : WRITEBACK;
                end
            end
            WRITEBACK: begin
                rf_we_c   = ir_q[11:7] != 5'd0;
                pc_d      = is_jal ? pc_target_i : pc_plus4;
                retired_d = retired_inc;
                state_d   = FETCH;
            end
            default: ;
        endcase
    end
    // strobes are gated by rst_n so they fall the moment reset asserts
    assign mem.imem_req  = rst_n && imem_req_c;
    assign mem.imem_addr = pc_q;
    assign mem.dmem_req  = rst_n && dmem_req_c;
    assign mem.dmem_we   = rst_n && dmem_we_c;
    assign rf_we_o       = rst_n && rf_we_c;
    // datapath controls follow the latched opcode only while an instruction is in flight
    assign dec_en        = state_q != FETCH && state_q != TRAP;
    assign alu_op_o      = !dec_en ? 2'b00 : is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
    assign alu_src_imm_o = dec_en && (is_i || is_ld || is_st);
    assign wb_sel_o      = !dec_en ? 2'b00 : (is_ld || is_st) ? 2'b01 : is_jal ? 2'b10 : 2'b00;
    assign pc_o          = pc_q;
    assign ir_o          = ir_q;
    assign funct3_o      = ir_q[14:12];
    assign funct7_o      = ir_q[31:25];
    assign trap_o        = state_q == TRAP;
    assign retired_o     = retired_q;
endmodule

// File: tb/tb_cayde_multicycle_ctrl.sv
// tb_cayde_multicycle_ctrl: scoreboard bench for the multicycle sequencer
module tb_cayde_multicycle_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o, pc_target_i, ir_o, retired_o;
    logic        branch_taken_i, alu_src_imm_o, rf_we_o, trap_o;
    logic [1:0]  alu_op_o, wb_sel_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_ret = 32'd0;
    always #5 clk = ~clk;
    cayde_multicycle_ctrl_if mem ();
    cayde_multicycle_ctrl #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mem),
        .pc_o(pc_o), .pc_target_i(pc_target_i), .branch_taken_i(branch_taken_i),
        .ir_o(ir_o), .alu_op_o(alu_op_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .alu_src_imm_o(alu_src_imm_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
        .trap_o(trap_o), .retired_o(retired_o)
    );
    typedef struct {
        int          cycles;
        logic [31:0] pc;
        logic [31:0] ret;
        int          rfwe;
        int          dreq;
        logic        dwe;
        logic [1:0]  aop;
        logic [1:0]  wb;
        logic        imm;
        logic [31:0] ir;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } rec_t;
    typedef struct {
        string       nm;
        logic [31:0] instr;
        int          waits;
        logic        taken;
        logic [31:0] tgt;
        logic        jump;
        int          cyc;
        int          rfwe;
        int          dreq;
        logic        dwe;
        logic [1:0]  aop;
        logic [1:0]  wb;
        logic        imm;
        logic [1:0]  care;
    } ent_t;
    rec_t sb[$];
    function automatic rec_t predict(ent_t t);
        rec_t e;
        e = '{default: 0};
        e.cycles = t.cyc;
        e.pc     = t.jump ? t.tgt : m_pc + 32'd4;
        e.ret    = m_ret + 32'd1;
        e.rfwe   = t.rfwe;
        e.dreq   = t.dreq;
        e.dwe    = t.dwe;
        e.aop    = t.aop;
        e.wb     = t.wb;
        e.imm    = t.imm;
        e.ir     = t.instr;
        e.f3     = t.instr[14:12];
        e.f7     = t.instr[31:25];
        return e;
    endfunction
    // issues one instruction from FETCH and observes it until retirement
    task automatic run_instr(input ent_t t, output rec_t o);
        logic [31:0] prev;
        o = '{default: 0};
        o.cycles = -1;
        prev = retired_o;
        mem.imem_rdata = t.instr;
        mem.imem_valid = 1'b1;
        branch_taken_i = t.taken;
        pc_target_i = t.tgt;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                o.ir = ir_o;
                o.wb = wb_sel_o;
                o.imm = alu_src_imm_o;
                o.f3 = funct3_o;
                o.f7 = funct7_o;
                mem.imem_rdata = 32'hFFFF_FFFF;
            end
            if (c == 2) o.aop = alu_op_o;
            if (rf_we_o) o.rfwe++;
            if (mem.dmem_req) begin
                o.dreq++;
                o.dwe = o.dwe | mem.dmem_we;
            end
            mem.dmem_ready = mem.dmem_req && (o.dreq > t.waits);
            if (retired_o !== prev) begin
                o.cycles = c;
                o.pc = pc_o;
                o.ret = retired_o;
                break;
            end
        end
        mem.imem_valid = 1'b0;
        mem.dmem_ready = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        mem.imem_valid = 1'b1;
        mem.imem_rdata = 32'h002081B3;
        mem.dmem_ready = 1'b1;
        branch_taken_i = 1'b0;
        pc_target_i = 32'h0;
        #12;
        checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, RESET_PC); end
        checks++; if (ir_o !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", ir_o); end
        checks++; if (retired_o !== 32'h0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired_o); end
        checks++; if (trap_o !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b want 0", trap_o); end
        checks++; if ({mem.imem_req, mem.dmem_req, mem.dmem_we, rf_we_o} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {mem.imem_req, mem.dmem_req, mem.dmem_we, rf_we_o}); end
        checks++; if ({alu_op_o, wb_sel_o, alu_src_imm_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {alu_op_o, wb_sel_o, alu_src_imm_o}); end
        @(negedge clk);
        mem.imem_valid = 1'b0;
        mem.dmem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if ({mem.imem_req, mem.imem_addr} !== {1'b1, RESET_PC}) begin errors++; $display("FAIL fetch_after_reset: got req=%b addr=%h want req=1 addr=%h", mem.imem_req, mem.imem_addr, RESET_PC); end
        @(negedge clk);
        m_pc = RESET_PC;
        m_ret = 32'd0;
    endtask
    task automatic test_alu();
        ent_t t[4];
        rec_t o, e;
        t[0] = '{"add",      32'h002081B3, 0, 1'b0, 32'h0, 1'b0, 4, 1, 0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b11};
        t[1] = '{"sub",      32'h403100B3, 0, 1'b0, 32'h0, 1'b0, 4, 1, 0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b11};
        t[2] = '{"addi_x0",  32'h00000013, 0, 1'b0, 32'h0, 1'b0, 4, 0, 0, 1'b0, 2'b11, 2'b00, 1'b1, 2'b11};
        t[3] = '{"ori_x5",   32'h00706293, 0, 1'b0, 32'h0, 1'b0, 4, 1, 0, 1'b0, 2'b11, 2'b00, 1'b1, 2'b11};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(predict(t[i]));
            m_pc = sb[$].pc;
            m_ret = sb[$].ret;
            run_instr(t[i], o);
            e = sb.pop_front();
            checks++; if (o.cycles !== e.cycles) begin errors++; $display("FAIL %s latency: got %0d want %0d", t[i].nm, o.cycles, e.cycles); end
            checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h want %h", t[i].nm, o.pc, e.pc); end
            checks++; if (o.ret !== e.ret) begin errors++; $display("FAIL %s retired: got %0d want %0d", t[i].nm, o.ret, e.ret); end
            checks++; if (o.rfwe !== e.rfwe) begin errors++; $display("FAIL %s rf_we_pulses: got %0d want %0d", t[i].nm, o.rfwe, e.rfwe); end
            checks++; if (o.aop !== e.aop) begin errors++; $display("FAIL %s alu_op: got %b want %b", t[i].nm, o.aop, e.aop); end
            checks++; if (o.imm !== e.imm) begin errors++; $display("FAIL %s alu_src_imm: got %b want %b", t[i].nm, o.imm, e.imm); end
            checks++; if (o.wb !== e.wb) begin errors++; $display("FAIL %s wb_sel: got %b want %b", t[i].nm, o.wb, e.wb); end
            checks++; if (o.ir !== e.ir) begin errors++; $display("FAIL %s ir: got %h want %h", t[i].nm, o.ir, e.ir); end
            checks++; if ({o.f7, o.f3} !== {e.f7, e.f3}) begin errors++; $display("FAIL %s funct7_3: got %h want %h", t[i].nm, {o.f7, o.f3}, {e.f7, e.f3}); end
            checks++; if (o.dreq !== 0) begin errors++; $display("FAIL %s dmem_req_cycles: got %0d want 0", t[i].nm, o.dreq); end
        end
    endtask
    task automatic test_mem();
        ent_t t[4];
        rec_t o, e;
        t[0] = '{"lw_wait3", 32'h0000A103, 3, 1'b0, 32'h0, 1'b0, 8, 1, 4, 1'b0, 2'b00, 2'b01, 1'b1, 2'b11};
        t[1] = '{"sw",       32'h0020A023, 0, 1'b0, 32'h0, 1'b0, 4, 0, 1, 1'b1, 2'b00, 2'b01, 1'b1, 2'b11};
        t[2] = '{"sw_wait2", 32'h0020A023, 2, 1'b0, 32'h0, 1'b0, 6, 0, 3, 1'b1, 2'b00, 2'b01, 1'b1, 2'b11};
        t[3] = '{"lw",       32'h0000A103, 0, 1'b0, 32'h0, 1'b0, 5, 1, 1, 1'b0, 2'b00, 2'b01, 1'b1, 2'b11};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(predict(t[i]));
            m_pc = sb[$].pc;
            m_ret = sb[$].ret;
            run_instr(t[i], o);
            e = sb.pop_front();
            checks++; if (o.cycles !== e.cycles) begin errors++; $display("FAIL %s latency: got %0d want %0d", t[i].nm, o.cycles, e.cycles); end
            checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h want %h", t[i].nm, o.pc, e.pc); end
            checks++; if (o.ret !== e.ret) begin errors++; $display("FAIL %s retired: got %0d want %0d", t[i].nm, o.ret, e.ret); end
            checks++; if (o.rfwe !== e.rfwe) begin errors++; $display("FAIL %s rf_we_pulses: got %0d want %0d", t[i].nm, o.rfwe, e.rfwe); end
            checks++; if (o.dreq !== e.dreq) begin errors++; $display("FAIL %s dmem_req_cycles: got %0d want %0d", t[i].nm, o.dreq, e.dreq); end
            checks++; if (o.dwe !== e.dwe) begin errors++; $display("FAIL %s dmem_we: got %b want %b", t[i].nm, o.dwe, e.dwe); end
            checks++; if (o.aop !== e.aop) begin errors++; $display("FAIL %s alu_op: got %b want %b", t[i].nm, o.aop, e.aop); end
            checks++; if ({o.wb, o.imm} !== {e.wb, e.imm}) begin errors++; $display("FAIL %s wb_imm: got %b want %b", t[i].nm, {o.wb, o.imm}, {e.wb, e.imm}); end
        end
    endtask
    task automatic test_branch_jal();
        ent_t t[6];
        rec_t o, e;
        t[0] = '{"beq_taken",  32'h00000063, 0, 1'b1, 32'h00000040, 1'b1, 3, 0, 0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b10};
        t[1] = '{"beq_not",    32'h00000063, 0, 1'b0, 32'h00000080, 1'b0, 3, 0, 0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b10};
        t[2] = '{"jal",        32'h008000EF, 0, 1'b0, 32'h00000100, 1'b1, 4, 1, 0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b01};
        t[3] = '{"bne_unalig", 32'h00001063, 0, 1'b1, 32'h00000003, 1'b1, 3, 0, 0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b10};
        t[4] = '{"beq_to_top", 32'h00000063, 0, 1'b1, 32'hFFFFFFFC, 1'b1, 3, 0, 0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b10};
        t[5] = '{"add_wrap",   32'h002081B3, 0, 1'b1, 32'h00000040, 1'b0, 4, 1, 0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b11};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(predict(t[i]));
            m_pc = sb[$].pc;
            m_ret = sb[$].ret;
            run_instr(t[i], o);
            e = sb.pop_front();
            checks++; if (o.cycles !== e.cycles) begin errors++; $display("FAIL %s latency: got %0d want %0d", t[i].nm, o.cycles, e.cycles); end
            checks++; if (o.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h want %h", t[i].nm, o.pc, e.pc); end
            checks++; if (o.ret !== e.ret) begin errors++; $display("FAIL %s retired: got %0d want %0d", t[i].nm, o.ret, e.ret); end
            checks++; if (o.rfwe !== e.rfwe) begin errors++; $display("FAIL %s rf_we_pulses: got %0d want %0d", t[i].nm, o.rfwe, e.rfwe); end
            checks++; if (o.aop !== e.aop) begin errors++; $display("FAIL %s alu_op: got %b want %b", t[i].nm, o.aop, e.aop); end
            if (t[i].care[0]) begin
                checks++; if (o.wb !== e.wb) begin errors++; $display("FAIL %s wb_sel: got %b want %b", t[i].nm, o.wb, e.wb); end
            end
            if (t[i].care[1]) begin
                checks++; if (o.imm !== e.imm) begin errors++; $display("FAIL %s alu_src_imm: got %b want %b", t[i].nm, o.imm, e.imm); end
            end
        end
    endtask
    task automatic test_mid_reset();
        bit seen = 0;
        mem.imem_rdata = 32'h0000A103;
        mem.imem_valid = 1'b1;
        mem.dmem_ready = 1'b0;
        @(negedge clk);
        mem.imem_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem.dmem_req;
        end
        checks++; if (!seen) begin errors++; $display("FAIL midreset_reach_memory: got no dmem_req want dmem_req"); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mem.dmem_req, mem.imem_req, rf_we_o} !== 3'b000) begin errors++; $display("FAIL midreset_strobes: got %b want 000", {mem.dmem_req, mem.imem_req, rf_we_o}); end
        checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL midreset_pc: got %h want %h", pc_o, RESET_PC); end
        checks++; if (retired_o !== 32'd0) begin errors++; $display("FAIL midreset_retired: got %0d want 0", retired_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({mem.imem_req, mem.imem_addr, mem.dmem_req} !== {1'b1, RESET_PC, 1'b0}) begin errors++; $display("FAIL midreset_fetch: got req=%b addr=%h dreq=%b want 1 %h 0", mem.imem_req, mem.imem_addr, mem.dmem_req, RESET_PC); end
        m_pc = RESET_PC;
        m_ret = 32'd0;
    endtask
    task automatic test_trap();
        int req_cnt = 0;
        logic [31:0] pc0, ret0;
        pc0 = pc_o;
        ret0 = retired_o;
        mem.imem_rdata = 32'h0000007F;
        mem.imem_valid = 1'b1;
        @(negedge clk);
        mem.imem_rdata = 32'h002081B3;
        @(negedge clk);
        checks++; if (trap_o !== 1'b1) begin errors++; $display("FAIL trap_flag: got %b want 1", trap_o); end
        for (int c = 0; c < 20; c++) begin
            mem.dmem_ready = 1'b1;
            @(negedge clk);
            if (mem.imem_req || mem.dmem_req || rf_we_o) req_cnt++;
        end
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL trap_requests: got %0d cycles want 0", req_cnt); end
        checks++; if ({pc_o, retired_o} !== {pc0, ret0}) begin errors++; $display("FAIL trap_frozen: got pc=%h ret=%0d want pc=%h ret=%0d", pc_o, retired_o, pc0, ret0); end
        checks++; if ({trap_o, alu_op_o, wb_sel_o, alu_src_imm_o} !== 6'b100000) begin errors++; $display("FAIL trap_ctrl: got %b want 100000", {trap_o, alu_op_o, wb_sel_o, alu_src_imm_o}); end
        mem.imem_valid = 1'b0;
        mem.dmem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (trap_o !== 1'b0) begin errors++; $display("FAIL trap_clear_by_reset: got %b want 0", trap_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (mem.imem_req !== 1'b1) begin errors++; $display("FAIL trap_exit_fetch: got %b want 1", mem.imem_req); end
    endtask
    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_mid_reset();
        test_branch_jal();
        test_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
